// File: rtl/mips_mem_dump_if.sv
// Bundle of the dump engine's control, memory-read and output-stream signals.
// The master modport is the dump engine; the slave modport is its environment
// (processor status, memory and downstream consumer).
interface mips_mem_dump_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // control
  logic              halted;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              err;
  // memory read port
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  // output stream
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    input  halted, start, base_addr, count, mem_rdata, out_ready,
    output busy, done, err, mem_rd_en, mem_addr,
           out_valid, out_data, out_addr, out_last
  );

  modport slave (
    output halted, start, base_addr, count, mem_rdata, out_ready,
    input  busy, done, err, mem_rd_en, mem_addr,
           out_valid, out_data, out_addr, out_last
  );
endinterface

// File: rtl/mips_mem_dump.sv
// Memory dump engine: while the processor is halted, reads count words starting
// at base_addr (wrapping modulo the memory depth) one at a time and presents each
// on a valid/ready stream, flagging the final word with out_last.
module mips_mem_dump #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input logic            clk1,
  input logic            rst_n,
  mips_mem_dump_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [2:0]        state_q,     state_d;
  logic [ADDR_W:0]   rem_q,       rem_d;        // words still to hand over
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;   // doubles as the walking address
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_last_q,  out_last_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;

  // Next-state and next-output logic for the dump sequencer.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    mem_rd_en_d = mem_rd_en_q;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (!bus.halted) begin
            err_d = 1'b1;
          end else if (bus.count == '0) begin
            state_d = S_FIN;
          end else begin
            rem_d       = bus.count;
            mem_addr_d  = bus.base_addr;
            mem_rd_en_d = 1'b1;
            state_d     = S_RD;
          end
        end
      end
      S_RD: begin
        // Read strobe is high for this single cycle; data arrives in CAP.
        mem_rd_en_d = 1'b0;
        state_d     = S_CAP;
      end
      S_CAP: begin
        out_data_d  = bus.mem_rdata;
        out_addr_d  = mem_addr_q;
        out_valid_d = 1'b1;
        out_last_d  = (rem_q == CNT_ONE);
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          rem_d       = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = S_FIN;
          end else begin
            mem_addr_d  = mem_addr_q + 1'b1;   // natural wrap at 2^ADDR_W
            mem_rd_en_d = 1'b1;
            state_d     = S_RD;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        mem_rd_en_d = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    // done is high exactly during the single FIN cycle.
    done_d = (state_d == S_FIN);
  end

  // State and output registers; reset wins over everything, including a pending capture.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mips_mem_dump.sv
// Self-checking bench for mips_mem_dump: a behavioural synchronous memory, a
// scoreboard of expected (addr, data, last) words and directed dump scenarios.
module tb_mips_mem_dump;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              l;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [DATA_W-1:0] mem [DEPTH];
  exp_t sb_q[$];

  int n_asserts = 0;
  int n_fail    = 0;
  int rd_cnt    = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int outv_cnt  = 0;
  bit rand_ready = 0;

  logic              prev_valid, prev_ready, prev_last;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_addr;

  mips_mem_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mips_mem_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk1  (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard pops on handshakes, hold-stability while stalled, event counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.mem_rd_en) rd_cnt++;
      if (bus.done)      done_cnt++;
      if (bus.err)       err_cnt++;
      if (bus.out_valid) outv_cnt++;
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data",  64'(bus.out_data),  64'(prev_data));
        check("hold_addr",  64'(bus.out_addr),  64'(prev_addr));
        check("hold_last",  64'(bus.out_last),  64'(prev_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        $display("word addr=%0d data=%0h last=%0b", bus.out_addr, bus.out_data, bus.out_last);
        if (sb_q.size() == 0) begin
          check("unexpected_word", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_addr", 64'(bus.out_addr), 64'(e.a));
          check("out_data", 64'(bus.out_data), 64'(e.d));
          check("out_last", 64'(bus.out_last), 64'(e.l));
        end
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_data  = bus.out_data;
      prev_addr  = bus.out_addr;
      prev_last  = bus.out_last;
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic push_words(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_t e;
      e.a = ADDR_W'((base + i) % DEPTH);
      e.d = mem[e.a];
      e.l = (i == cnt - 1);
      sb_q.push_back(e);
    end
  endtask

  // One-cycle start pulse; returns just after the accepting edge.
  task automatic do_start(input int base, input int cnt, input logic rdy);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = ADDR_W'(base);
    bus.count     = (ADDR_W+1)'(cnt);
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Returns at the falling edge inside the done cycle.
  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    if (k == budget) check("timeout_done", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    if (k == budget) check("timeout_valid", 64'd0, 64'd1);
  endtask

  int rd0, dn0, er0, ov0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = (i * 32'h9E3779B1) ^ 32'h00005A5A;
    mem[120]  = 32'd85;
    mem[121]  = 32'd7;
    rst_n         = 1'b0;
    bus.halted    = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_addr",  64'(bus.out_addr),  64'd0);
    check("rst_out_last",  64'(bus.out_last),  64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_done",      64'(bus.done),      64'd0);
    check("rst_err",       64'(bus.err),       64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Two-word dump, no backpressure, with latency checks
    #1 rd0 = rd_cnt; dn0 = done_cnt;
    push_words(120, 2);
    do_start(120, 2, 1'b1);
    @(negedge clk);
    check("rd_strobe", 64'(bus.mem_rd_en), 64'd1);
    check("rd_addr",   64'(bus.mem_addr),  64'd120);
    check("rd_busy",   64'(bus.busy),      64'd1);
    @(negedge clk);
    check("cap_strobe", 64'(bus.mem_rd_en), 64'd0);
    check("cap_valid",  64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    wait_done(200);
    @(negedge clk);
    #1;
    check("a_rd_cycles", 64'(rd_cnt - rd0),   64'd2);
    check("a_done_cnt",  64'(done_cnt - dn0), 64'd1);
    check("a_sb_empty",  64'(sb_q.size()),    64'd0);

    // Same dump, first word stalled for 5 cycles
    rd0 = rd_cnt;
    push_words(120, 2);
    do_start(120, 2, 1'b0);
    wait_valid(50);
    #1 rd0 = rd_cnt;
    repeat (5) begin
      @(negedge clk);
      check("stall_data", 64'(bus.out_data), 64'd85);
    end
    #1 check("stall_no_read", 64'(rd_cnt), 64'(rd0));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done(200);
    @(negedge clk);
    #1 check("b_sb_empty", 64'(sb_q.size()), 64'd0);

    // Start while not halted
    bus.halted = 1'b0;
    rd0 = rd_cnt; er0 = err_cnt;
    do_start(200, 3, 1'b1);
    @(negedge clk);
    check("err_pulse", 64'(bus.err),  64'd1);
    check("err_busy",  64'(bus.busy), 64'd0);
    @(negedge clk);
    check("err_once",  64'(bus.err),  64'd0);
    check("err_busy2", 64'(bus.busy), 64'd0);
    #1;
    check("err_no_read", 64'(rd_cnt - rd0),  64'd0);
    check("err_count",   64'(err_cnt - er0), 64'd1);
    bus.halted = 1'b1;

    // Address wrap
    push_words(1022, 4);
    do_start(1022, 4, 1'b1);
    wait_done(200);
    @(negedge clk);
    #1 check("wrap_sb_empty", 64'(sb_q.size()), 64'd0);

    // Zero-length dump
    rd0 = rd_cnt; ov0 = outv_cnt; dn0 = done_cnt;
    do_start(50, 0, 1'b1);
    @(negedge clk);
    check("zero_done", 64'(bus.done), 64'd1);
    check("zero_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("zero_done_end", 64'(bus.done), 64'd0);
    check("zero_idle",     64'(bus.busy), 64'd0);
    #1;
    check("zero_no_read",  64'(rd_cnt - rd0),   64'd0);
    check("zero_no_valid", 64'(outv_cnt - ov0), 64'd0);
    check("zero_done_cnt", 64'(done_cnt - dn0), 64'd1);

    // Back-to-back: restart in the IDLE cycle right after FIN
    dn0 = done_cnt;
    push_words(300, 2);
    do_start(300, 2, 1'b1);
    wait_done(200);
    push_words(10, 1);
    do_start(10, 1, 1'b1);
    wait_done(200);
    @(negedge clk);
    #1;
    check("b2b_done_cnt", 64'(done_cnt - dn0), 64'd2);
    check("b2b_sb_empty", 64'(sb_q.size()),    64'd0);

    // Random backpressure, halted drop and ignored start mid-dump
    er0 = err_cnt;
    push_words(1020, 7);
    do_start(1020, 7, 1'b1);
    rand_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    bus.halted    = 1'b0;
    bus.start     = 1'b1;
    bus.base_addr = ADDR_W'(5);
    bus.count     = (ADDR_W+1)'(3);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(500);
    rand_ready = 0;
    bus.halted = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    check("busy_start_no_err", 64'(err_cnt - er0), 64'd0);
    check("rnd_sb_empty",      64'(sb_q.size()),   64'd0);

    // Reset while presenting a word, then a normal dump
    push_words(120, 1);
    do_start(120, 1, 1'b0);
    wait_valid(50);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst2_out_data",  64'(bus.out_data),  64'd0);
    check("rst2_out_addr",  64'(bus.out_addr),  64'd0);
    check("rst2_busy",      64'(bus.busy),      64'd0);
    check("rst2_done",      64'(bus.done),      64'd0);
    check("rst2_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    push_words(120, 1);
    do_start(120, 1, 1'b1);
    wait_done(200);
    @(negedge clk);
    #1 check("rst2_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
